uart_rx_deserializer: RTL and testbench
=======================================

// Module: uart_rx_deserializer
// PURPOSE
//   Serial UART receiver (8N1, LSB first, 16x oversampled) that feeds the
//   memory-mapped peripheral/RAM block. Produces each received byte on RX_DATA
//   with a one-cycle RX_STATUS strobe, the producer side of the RX_DATA/RX_STATUS
//   pair the peripheral block consumes. Also flags framing errors and line breaks.
// PARAMETERS
//   OVERSAMPLE_DIV  326  clk cycles per 1/16-bit tick (50 MHz / 9600 baud / 16)
//   DIV_W           16   width of tick divider counter, must hold OVERSAMPLE_DIV-1
// PORTS
//   clk            in   1  system clock, all logic on posedge
//   reset          in   1  synchronous, active-high reset
//   UART_RX        in   1  asynchronous serial line, idle high
//   RX_DATA        out  8  last correctly framed byte, held until next good frame
//   RX_STATUS      out  1  one-cycle strobe: new byte valid on RX_DATA
//   rx_frame_err   out  1  one-cycle strobe: stop bit sampled as 0
//   rx_busy        out  1  high while state != IDLE
// BEHAVIOUR
//   Reset (sync, active-high): RX_DATA=8'h00, RX_STATUS=0, rx_frame_err=0,
//     rx_busy=0, state=IDLE, sync flops=2'b11, counters=0. Reset wins over all
//     other events, including mid-frame; partial byte is discarded.
//   Input: 2-flop synchronizer rx_s; all decisions use rx_s only (2-clk lag).
//   Tick: div_cnt counts 0..OVERSAMPLE_DIV-1; tick=1 when div_cnt==DIV-1.
//     div_cnt and tick_cnt(4b) cleared on start detection; tick_cnt wraps 15->0.
//   Bit sample: rx_s captured at tick_cnt 7,8,9; majority of 3 is the bit value,
//     resolved on the tick with tick_cnt==9.
//   FSM:
//     IDLE  : rx_s==0 -> START (clear counters). rx_busy=0.
//     START : at vote: bit==0 -> DATA, bit_idx=0; bit==1 -> IDLE (glitch, no flag).
//     DATA  : each vote shifts bit into shreg[7] (shreg>>1, LSB first);
//             after bit_idx==7 vote -> STOP; bit_idx increments otherwise.
//     STOP  : at vote: bit==1 -> RX_DATA<=shreg, RX_STATUS=1 for the next
//             cycle only, -> IDLE. bit==0 -> rx_frame_err=1 one cycle, RX_DATA
//             unchanged, -> BREAK.
//     BREAK : wait for rx_s==1, then -> IDLE (no retrigger on held-low line).
//   Return to IDLE at stop-bit mid-sample: next start edge may follow at once
//     (back-to-back frames, zero idle time, must be accepted).
//   RX_STATUS and rx_frame_err never both high; never high two cycles in a row.
//   Latency: strobe ~9.6 bit periods (+2 clk sync) after start falling edge.
//   No flow control: a new byte overwrites RX_DATA; consumer must read it
//     within one frame time (~10 bit periods).
// TESTING  (OVERSAMPLE_DIV=4 -> 64 clk/bit)
//   1 Reset: hold reset 3 clk, UART_RX=1 -> RX_DATA=00, RX_STATUS=0,
//     rx_frame_err=0, rx_busy=0; all stay 0 for 1000 clk idle.
//   2 Frame 0xA5 at 64 clk/bit -> exactly one RX_STATUS pulse, RX_DATA=A5,
//     pulse at 9.6 bit periods (+/-8 clk) after start edge, rx_busy low after.
//   3 Line low for 16 clk then high -> START aborts, no RX_STATUS, no
//     rx_frame_err, rx_busy back to 0 within 1 bit period.
//   4 0x3C with stop bit=0, line held low 3 bit periods, then high, then 0x5A
//     -> one rx_frame_err pulse, RX_DATA stays A5, no second err during low
//     hold; then RX_STATUS with RX_DATA=5A.
//   5 Back-to-back 0x00,0xFF,0x81 with no idle gap -> three RX_STATUS pulses,
//     RX_DATA sequence 00,FF,81, no frame errors.
//   6 Reset asserted during data bit 4 of 0xC3, released, then frame 0x81 with
//     one 4-clk inverted glitch at a bit mid-sample -> no strobe for C3,
//     RX_DATA=81 after 2nd frame (majority vote rejects glitch).

Source files
------------

// File: rtl/uart_rx_deserializer.sv
// uart_rx_deserializer
// 8N1 UART receiver, LSB first, 16x oversampled with a 3-sample majority vote
// at mid-bit. Emits each good byte on RX_DATA with a one-cycle RX_STATUS
// strobe, flags a zero stop bit with rx_frame_err, and then parks in BREAK
// until the line returns high, so a held-low line raises only one error.
module uart_rx_deserializer #(
  parameter int unsigned OVERSAMPLE_DIV = 326,
  parameter int unsigned DIV_W          = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       UART_RX,
  output logic [7:0] RX_DATA,
  output logic       RX_STATUS,
  output logic       rx_frame_err,
  output logic       rx_busy
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } state_e;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(OVERSAMPLE_DIV - 32'd1);
  localparam logic [DIV_W-1:0] DIV_ZERO = DIV_W'(32'd0);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(32'd1);

  // Two-of-three vote across the mid-bit samples.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    maj3 = (a & b) | (a & c) | (b & c);
  endfunction

  state_e           state_q, state_d;
  logic [1:0]       sync_q, sync_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [3:0]       tick_cnt_q, tick_cnt_d;
  logic [1:0]       samp_q, samp_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shreg_q, shreg_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_status_q, rx_status_d;
  logic             frame_err_q, frame_err_d;
  logic             busy_q, busy_d;

  logic rx_s;
  logic tick_s;
  logic vote_s;
  logic bit_s;

  // Next-state logic: synchronizer, tick divider, mid-bit sampling and frame FSM.
  always_comb begin
    state_d     = state_q;
    div_cnt_d   = div_cnt_q;
    tick_cnt_d  = tick_cnt_q;
    samp_d      = samp_q;
    bit_idx_d   = bit_idx_q;
    shreg_d     = shreg_q;
    rx_data_d   = rx_data_q;
    rx_status_d = 1'b0;
    frame_err_d = 1'b0;

    // The raw line is asynchronous; only the second flop output is trusted.
    sync_d = {sync_q[0], UART_RX};
    rx_s   = sync_q[1];

    tick_s = (div_cnt_q == DIV_LAST);
    if (tick_s) begin
      div_cnt_d  = DIV_ZERO;
      tick_cnt_d = tick_cnt_q + 4'd1;
    end else begin
      div_cnt_d  = div_cnt_q + DIV_ONE;
    end

    // Samples at ticks 7 and 8 are held; the third comes live on tick 9.
    if (tick_s && (tick_cnt_q == 4'd7)) begin
      samp_d[0] = rx_s;
    end else if (tick_s && (tick_cnt_q == 4'd8)) begin
      samp_d[1] = rx_s;
    end else begin
      samp_d = samp_q;
    end

    vote_s = tick_s && (tick_cnt_q == 4'd9);
    bit_s  = maj3(samp_q[0], samp_q[1], rx_s);

    case (state_q)
      ST_IDLE: begin
        // Align the bit timing to the detected start edge.
        if (!rx_s) begin
          state_d    = ST_START;
          div_cnt_d  = DIV_ZERO;
          tick_cnt_d = 4'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (vote_s) begin
          if (!bit_s) begin
            state_d   = ST_DATA;
            bit_idx_d = 3'd0;
          end else begin
            state_d = ST_IDLE;  // too short to be a start bit
          end
        end else begin
          state_d = ST_START;
        end
      end
      ST_DATA: begin
        if (vote_s) begin
          shreg_d = {bit_s, shreg_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_STOP: begin
        // Leaving at the stop-bit vote lets a new start bit follow with no gap.
        if (vote_s) begin
          if (bit_s) begin
            rx_data_d   = shreg_q;
            rx_status_d = 1'b1;
            state_d     = ST_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = ST_BREAK;
          end
        end else begin
          state_d = ST_STOP;
        end
      end
      ST_BREAK: begin
        if (rx_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_BREAK;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset discards any partial frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      sync_q      <= 2'b11;
      div_cnt_q   <= DIV_ZERO;
      tick_cnt_q  <= 4'd0;
      samp_q      <= 2'b00;
      bit_idx_q   <= 3'd0;
      shreg_q     <= 8'h00;
      rx_data_q   <= 8'h00;
      rx_status_q <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      div_cnt_q   <= div_cnt_d;
      tick_cnt_q  <= tick_cnt_d;
      samp_q      <= samp_d;
      bit_idx_q   <= bit_idx_d;
      shreg_q     <= shreg_d;
      rx_data_q   <= rx_data_d;
      rx_status_q <= rx_status_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
    end
  end

  assign RX_DATA      = rx_data_q;
  assign RX_STATUS    = rx_status_q;
  assign rx_frame_err = frame_err_q;
  assign rx_busy      = busy_q;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Self-checking bench for uart_rx_deserializer with OVERSAMPLE_DIV=4 (64 clk/bit).
module tb_uart_rx_deserializer;

  localparam int BIT_CLK = 64;

  logic       clk;
  logic       reset;
  logic       UART_RX;
  logic [7:0] RX_DATA;
  logic       RX_STATUS;
  logic       rx_frame_err;
  logic       rx_busy;

  uart_rx_deserializer #(
    .OVERSAMPLE_DIV(4),
    .DIV_W(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .UART_RX(UART_RX),
    .RX_DATA(RX_DATA),
    .RX_STATUS(RX_STATUS),
    .rx_frame_err(rx_frame_err),
    .rx_busy(rx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor, sampled on the falling edge.
  logic [7:0] st_data[$];
  int         st_cyc[$];
  int         n_err = 0;
  int         n_busy = 0;
  int         viol = 0;
  logic       prev_strobe = 1'b0;

  always @(negedge clk) begin
    if (RX_STATUS) begin
      st_data.push_back(RX_DATA);
      st_cyc.push_back(cyc);
    end
    if (rx_frame_err) n_err = n_err + 1;
    if (rx_busy) n_busy = n_busy + 1;
    if (RX_STATUS && rx_frame_err) viol = viol + 1;
    if ((RX_STATUS || rx_frame_err) && prev_strobe) viol = viol + 1;
    prev_strobe = RX_STATUS || rx_frame_err;
  end

  int errors = 0;
  int checks = 0;
  int start_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks = checks + 1;
    if (act < lo || act > hi) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Drive one frame; glitch_pos selects a frame bit (0=start..9=stop) that gets
  // a 4-clk inverted pulse around its second mid-bit sample, -1 for none.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int glitch_pos);
    logic [9:0] bits;
    bits = {stop, d, 1'b0};
    for (int p = 0; p < 10; p++) begin
      if (p == 0) start_cyc = cyc;
      UART_RX = bits[p];
      if (p == glitch_pos) begin
        repeat (35) @(negedge clk);
        UART_RX = ~bits[p];
        repeat (4) @(negedge clk);
        UART_RX = bits[p];
        repeat (BIT_CLK - 39) @(negedge clk);
      end else begin
        repeat (BIT_CLK) @(negedge clk);
      end
    end
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_status;
    int         exp_err;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int s0;
    int e0;
    int b0;
    int lat;
    logic [9:0] c3_bits;

    vecs[0] = '{8'hA5, 1'b1, 1, 0, 8'hA5};
    vecs[1] = '{8'h3C, 1'b0, 0, 1, 8'hA5};
    vecs[2] = '{8'h5A, 1'b1, 1, 0, 8'h5A};
    vecs[3] = '{8'hFF, 1'b0, 0, 1, 8'h5A};
    vecs[4] = '{8'h81, 1'b1, 1, 0, 8'h81};
    vecs[5] = '{8'h00, 1'b1, 1, 0, 8'h00};

    // 1: reset, then a long idle line.
    reset = 1'b1;
    UART_RX = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_rx_data", 32'(RX_DATA), 32'h00);
    check("reset_rx_status", 32'(RX_STATUS), 32'h0);
    check("reset_frame_err", 32'(rx_frame_err), 32'h0);
    check("reset_busy", 32'(rx_busy), 32'h0);
    reset = 1'b0;
    b0 = n_busy;
    repeat (1000) @(negedge clk);
    check("idle_no_status", 32'(st_data.size()), 32'd0);
    check("idle_no_err", 32'(n_err), 32'd0);
    check("idle_no_busy", 32'(n_busy - b0), 32'd0);
    check("idle_rx_data", 32'(RX_DATA), 32'h00);

    // 2 and 4: table of single frames with good or zero stop bits.
    for (int i = 0; i < 6; i++) begin
      s0 = st_data.size();
      e0 = n_err;
      send_frame(vecs[i].data, vecs[i].stop, -1);
      if (!vecs[i].stop) repeat (3 * BIT_CLK) @(negedge clk);
      UART_RX = 1'b1;
      if (i == 0) begin
        lat = (st_cyc.size() > s0) ? (st_cyc[s0] - start_cyc) : -1;
        check_range("latency_a5", lat, 608, 625);
      end
      repeat (2 * BIT_CLK) @(negedge clk);
      check($sformatf("vec%0d_status_count", i), 32'(st_data.size() - s0), 32'(vecs[i].exp_status));
      check($sformatf("vec%0d_err_count", i), 32'(n_err - e0), 32'(vecs[i].exp_err));
      check($sformatf("vec%0d_rx_data", i), 32'(RX_DATA), 32'(vecs[i].exp_data));
      check($sformatf("vec%0d_busy_after", i), 32'(rx_busy), 32'h0);
    end

    // 3: short low pulse aborts in START.
    s0 = st_data.size();
    e0 = n_err;
    b0 = n_busy;
    UART_RX = 1'b0;
    repeat (16) @(negedge clk);
    UART_RX = 1'b1;
    repeat (BIT_CLK - 16) @(negedge clk);
    check("glitch_busy_seen", 32'(n_busy > b0), 32'h1);
    check("glitch_busy_clear", 32'(rx_busy), 32'h0);
    repeat (BIT_CLK) @(negedge clk);
    check("glitch_no_status", 32'(st_data.size() - s0), 32'd0);
    check("glitch_no_err", 32'(n_err - e0), 32'd0);

    // 5: back-to-back frames with no idle gap.
    s0 = st_data.size();
    e0 = n_err;
    send_frame(8'h00, 1'b1, -1);
    send_frame(8'hFF, 1'b1, -1);
    send_frame(8'h81, 1'b1, -1);
    UART_RX = 1'b1;
    repeat (2 * BIT_CLK) @(negedge clk);
    check("b2b_status_count", 32'(st_data.size() - s0), 32'd3);
    if (st_data.size() >= s0 + 3) begin
      check("b2b_data0", 32'(st_data[s0]), 32'h00);
      check("b2b_data1", 32'(st_data[s0 + 1]), 32'hFF);
      check("b2b_data2", 32'(st_data[s0 + 2]), 32'h81);
    end
    check("b2b_no_err", 32'(n_err - e0), 32'd0);

    // 6: reset during data bit 4 of 0xC3, then 0x81 with a glitched bit.
    s0 = st_data.size();
    e0 = n_err;
    c3_bits = {1'b1, 8'hC3, 1'b0};
    for (int p = 0; p < 5; p++) begin
      UART_RX = c3_bits[p];
      repeat (BIT_CLK) @(negedge clk);
    end
    UART_RX = c3_bits[5];
    repeat (30) @(negedge clk);
    reset = 1'b1;
    UART_RX = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("midreset_rx_data", 32'(RX_DATA), 32'h00);
    check("midreset_busy", 32'(rx_busy), 32'h0);
    repeat (3 * BIT_CLK) @(negedge clk);
    check("midreset_no_status", 32'(st_data.size() - s0), 32'd0);
    send_frame(8'h81, 1'b1, 4);
    UART_RX = 1'b1;
    repeat (2 * BIT_CLK) @(negedge clk);
    check("vote_status_count", 32'(st_data.size() - s0), 32'd1);
    check("vote_rx_data", 32'(RX_DATA), 32'h81);
    check("vote_no_err", 32'(n_err - e0), 32'd0);

    // Strobes never overlap and never last two cycles.
    check("strobe_violations", 32'(viol), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
